// File: rtl/key_expand_seq.sv
// Iterative AES-128 key schedule: loads a cipher key and emits round keys
// 0..NR, one per rk_valid/rk_ready handshake, one expansion step per cycle.
// Optional macro KEY_EXP_LAST_KEY_EN adds a last_key output capturing the
// final round key (seed for the decryption schedule).

// Combinational AES forward S-box.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup.
    always_comb begin
        y = SBOX[a];
    end
endmodule

module key_expand_seq #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic [7:0]   rcon_out,
    output logic         done
`ifdef KEY_EXP_LAST_KEY_EN
    ,
    output logic [127:0] last_key
`endif
);
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t       state, state_nxt;
    logic [127:0] rk_out_nxt;
    logic [3:0]   rk_round_nxt;
    logic [7:0]   rcon_out_nxt;
    logic [7:0]   next_rcon, next_rcon_nxt;
    logic         done_nxt;
`ifdef KEY_EXP_LAST_KEY_EN
    logic [127:0] last_key_nxt;
`endif

    logic [31:0]  w0, w1, w2, w3, rot, sub, temp;
    logic [127:0] expanded;

    assign w0  = rk_out[127:96];
    assign w1  = rk_out[95:64];
    assign w2  = rk_out[63:32];
    assign w3  = rk_out[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    aes_sbox u_sbox0 (.a(rot[31:24]), .y(sub[31:24]));
    aes_sbox u_sbox1 (.a(rot[23:16]), .y(sub[23:16]));
    aes_sbox u_sbox2 (.a(rot[15:8]),  .y(sub[15:8]));
    aes_sbox u_sbox3 (.a(rot[7:0]),   .y(sub[7:0]));

    // One AES-128 expansion step from the key currently on rk_out.
    always_comb begin
        temp = sub ^ {next_rcon, 24'h000000};
        expanded[127:96] = w0 ^ temp;
        expanded[95:64]  = w1 ^ expanded[127:96];
        expanded[63:32]  = w2 ^ expanded[95:64];
        expanded[31:0]   = w3 ^ expanded[63:32];
    end

    assign rk_valid = (state == EMIT);
    assign busy     = (state == EMIT);

    // Next-state and datapath update; everything holds unless a load or handshake occurs.
    always_comb begin
        state_nxt     = state;
        rk_out_nxt    = rk_out;
        rk_round_nxt  = rk_round;
        rcon_out_nxt  = rcon_out;
        next_rcon_nxt = next_rcon;
        done_nxt      = 1'b0;
`ifdef KEY_EXP_LAST_KEY_EN
        last_key_nxt  = last_key;
`endif
        case (state)
            IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done) begin
                    state_nxt     = EMIT;
                    rk_out_nxt    = key_in;
                    rk_round_nxt  = '0;
                    rcon_out_nxt  = '0;
                    next_rcon_nxt = 8'h01;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (rk_round == LAST_ROUND) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
`ifdef KEY_EXP_LAST_KEY_EN
                        last_key_nxt = rk_out;
`endif
                    end else begin
                        rk_out_nxt    = expanded;
                        rk_round_nxt  = rk_round + 4'd1;
                        rcon_out_nxt  = next_rcon;
                        next_rcon_nxt = {next_rcon[6:0], 1'b0} ^ (next_rcon[7] ? 8'h1b : 8'h00);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rk_out    <= '0;
            rk_round  <= '0;
            rcon_out  <= '0;
            next_rcon <= '0;
            done      <= 1'b0;
`ifdef KEY_EXP_LAST_KEY_EN
            last_key  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            rk_out    <= rk_out_nxt;
            rk_round  <= rk_round_nxt;
            rcon_out  <= rcon_out_nxt;
            next_rcon <= next_rcon_nxt;
            done      <= done_nxt;
`ifdef KEY_EXP_LAST_KEY_EN
            last_key  <= last_key_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_key_expand_seq.sv
// Scoreboard bench for key_expand_seq: a default NR=10 instance and an NR=1
// instance; expected round keys come from FIPS-197 reference values.
`timescale 1ns/1ps
module tb_key_expand_seq;
    typedef struct {
        logic [127:0] key;
        logic [3:0]   round;
        logic [7:0]   rcon;
        bit           chk;
    } exp_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst, start, rk_ready, start1, rk_ready1;
    logic [127:0] key_in, key_in1;
    logic         busy, rk_valid, done, busy1, rk_valid1, done1;
    logic [127:0] rk_out, rk_out1;
    logic [3:0]   rk_round, rk_round1;
    logic [7:0]   rcon_out, rcon_out1;
`ifdef KEY_EXP_LAST_KEY_EN
    logic [127:0] last_key, last_key1;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t sb1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    key_expand_seq dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
        .rk_round(rk_round), .rcon_out(rcon_out), .done(done)
`ifdef KEY_EXP_LAST_KEY_EN
        , .last_key(last_key)
`endif
    );

    key_expand_seq #(.NR(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .key_in(key_in1), .busy(busy1),
        .rk_valid(rk_valid1), .rk_ready(rk_ready1), .rk_out(rk_out1),
        .rk_round(rk_round1), .rcon_out(rcon_out1), .done(done1)
`ifdef KEY_EXP_LAST_KEY_EN
        , .last_key(last_key1)
`endif
    );

    function automatic logic [127:0] fips_rk(input int r);
        case (r)
            0:  return FIPS_KEY;
            1:  return 128'ha0fafe1788542cb123a339392a6c7605;
            2:  return 128'hf2c295f27a96b9435935807a7359f67f;
            3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  return 128'head27321b58dbad2312bf5607f8d292f;
            9:  return 128'hac7766f319fadc2128d12941575c006e;
            default: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        endcase
    endfunction

    function automatic logic [7:0] rcon_of(input int r);
        case (r)
            0: return 8'h00;  1: return 8'h01;  2: return 8'h02;  3: return 8'h04;
            4: return 8'h08;  5: return 8'h10;  6: return 8'h20;  7: return 8'h40;
            8: return 8'h80;  9: return 8'h1b;  default: return 8'h36;
        endcase
    endfunction

    task automatic push_fips();
        for (int r = 0; r <= 10; r++) sb.push_back('{fips_rk(r), 4'(r), rcon_of(r), 1'b1});
    endtask

    task automatic push_zero();
        for (int r = 0; r <= 10; r++) begin
            exp_t e;
            e = '{128'h0, 4'(r), rcon_of(r), 1'b0};
            if (r == 0) begin e.key = 128'h0; e.chk = 1'b1; end
            if (r == 1) begin e.key = 128'h62636363626363636263636362636363; e.chk = 1'b1; end
            if (r == 10) begin e.key = 128'hb4ef5bcb3e92e21123e951cf6f8f188e; e.chk = 1'b1; end
            sb.push_back(e);
        end
    endtask

    // Scoreboard consumer for the NR=10 instance.
    always @(negedge clk) begin
        if (!rst && rk_valid && rk_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: handshake round=%0d, expected none", rk_round);
            end else begin
                e0 = sb.pop_front();
                if (rk_round !== e0.round) begin
                    errors++;
                    $display("FAIL round: got %0d want %0d", rk_round, e0.round);
                end
                checks++;
                if (rcon_out !== e0.rcon) begin
                    errors++;
                    $display("FAIL rcon r%0d: got %h want %h", e0.round, rcon_out, e0.rcon);
                end
                if (e0.chk) begin
                    checks++;
                    if (rk_out !== e0.key) begin
                        errors++;
                        $display("FAIL rk r%0d: got %h want %h", e0.round, rk_out, e0.key);
                    end
                end
            end
        end
    end

    // Scoreboard consumer for the NR=1 instance.
    always @(negedge clk) begin
        if (!rst && rk_valid1 && rk_ready1) begin
            checks++;
            if (sb1.size() == 0) begin
                errors++;
                $display("FAIL sb1_underflow: handshake round=%0d, expected none", rk_round1);
            end else begin
                e1 = sb1.pop_front();
                if ({rk_round1, rcon_out1, rk_out1} !== {e1.round, e1.rcon, e1.key}) begin
                    errors++;
                    $display("FAIL nr1_key: got r%0d %h %h want r%0d %h %h",
                             rk_round1, rcon_out1, rk_out1, e1.round, e1.rcon, e1.key);
                end
            end
        end
    end

    task automatic pulse_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Runs until shortly after done; optionally pokes start at round inj and during done.
    task automatic run_sched(input int budget, input int inj, output int first_v,
                             output int done_at, output int done_cnt);
        first_v = -1; done_at = -1; done_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            start = 1'b0;
            if (rk_valid && first_v < 0) first_v = i;
            if (done) begin done_cnt++; done_at = i; end
            if (inj >= 0 && ((rk_valid && int'(rk_round) == inj) || done)) begin
                start = 1'b1;
                key_in = ~FIPS_KEY;
            end
            if (done_cnt > 0 && i >= done_at + 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
        start1 = 1'b0; key_in1 = '0; rk_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rk_valid, busy, done, rk_valid1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got v=%b b=%b d=%b v1=%b want 0", rk_valid, busy, done, rk_valid1);
        end
        checks++;
        if ({rk_out, rk_round, rcon_out} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h r%0d %h want 0", rk_out, rk_round, rcon_out);
        end
`ifdef KEY_EXP_LAST_KEY_EN
        checks++;
        if (last_key !== '0) begin errors++; $display("FAIL reset_last_key: got %h want 0", last_key); end
`endif
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wins: got rk_valid=%b want 0", rk_valid);
        end
    endtask

    task automatic test_fips();
        int fv, da, dc;
        push_fips();
        pulse_start(FIPS_KEY);
        checks++;
        if ({rk_valid, busy} !== 2'b11) begin
            errors++;
            $display("FAIL load_latency: got v=%b b=%b want 11", rk_valid, busy);
        end
        run_sched(40, -1, fv, da, dc);
        checks++;
        if (dc != 1 || da - fv != 11) begin
            errors++;
            $display("FAIL fips_done: got count=%0d delay=%0d want 1 and 11", dc, da - fv);
        end
        checks++;
        if ({rk_valid, busy, rk_out} !== {2'b00, fips_rk(10)}) begin
            errors++;
            $display("FAIL fips_end: got v=%b b=%b %h want 0 0 %h", rk_valid, busy, rk_out, fips_rk(10));
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL fips_drain: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_zero_key();
        int fv, da, dc;
        push_zero();
        pulse_start('0);
        run_sched(40, -1, fv, da, dc);
        checks++;
        if (dc != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL zero_done: got count=%0d left=%0d want 1 and 0", dc, sb.size());
        end
`ifdef KEY_EXP_LAST_KEY_EN
        checks++;
        if (last_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++;
            $display("FAIL zero_last_key: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", last_key);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [139:0] prev_bus;
        logic         prev_vld, prev_rdy;
        int           dc;
        dc = 0; prev_vld = 1'b0; prev_rdy = 1'b0; prev_bus = '0;
        push_fips();
        pulse_start(FIPS_KEY);
        for (int i = 0; i < 300 && dc == 0; i++) begin
            if (prev_vld && !prev_rdy) begin
                checks++;
                if (!rk_valid || {rk_out, rk_round, rcon_out} !== prev_bus) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h want v=1 %h", rk_valid,
                             {rk_out, rk_round, rcon_out}, prev_bus);
                end
            end
            if (done) dc++;
            prev_vld = rk_valid;
            prev_bus = {rk_out, rk_round, rcon_out};
            rk_ready = 1'($urandom_range(0, 1));
            prev_rdy = rk_ready;
            @(posedge clk); #1;
        end
        rk_ready = 1'b1;
        checks++;
        if (dc != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_done: got done=%0d left=%0d want 1 and 0", dc, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int fv, da, dc;
        push_fips();
        pulse_start(FIPS_KEY);
        run_sched(40, 4, fv, da, dc);
        checks++;
        if (dc != 1 || rk_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL start_ignored: got done=%0d v=%b left=%0d want 1 0 0", dc, rk_valid, sb.size());
        end
        checks++;
        if (rk_out !== fips_rk(10)) begin
            errors++;
            $display("FAIL start_ignored_key: got %h want %h", rk_out, fips_rk(10));
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        push_fips();
        pulse_start(FIPS_KEY);
        for (int i = 0; i < 20 && !hit; i++) begin
            if (rk_valid && rk_round == 4'd6) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_reach: got no round 6 want round 6 within 20 cycles"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        checks++;
        if ({rk_valid, busy, done, rk_out, rk_round, rcon_out} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b b=%b d=%b %h r%0d %h want all 0",
                     rk_valid, busy, done, rk_out, rk_round, rcon_out);
        end
`ifdef KEY_EXP_LAST_KEY_EN
        checks++;
        if (last_key !== '0) begin errors++; $display("FAIL mid_last_key: got %h want 0", last_key); end
`endif
        test_fips();
    endtask

    task automatic test_nr1();
        for (int pass = 0; pass < 2; pass++) begin
            int fv, da, dc;
            fv = -1; da = -1; dc = 0;
            sb1.push_back('{FIPS_KEY, 4'd0, 8'h00, 1'b1});
            sb1.push_back('{fips_rk(1), 4'd1, 8'h01, 1'b1});
            key_in1 = FIPS_KEY; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (rk_valid1 && fv < 0) fv = i;
                if (done1) begin dc++; da = i; end
                if (dc > 0 && i >= da + 2) break;
                @(posedge clk); #1;
            end
            checks++;
            if (dc != 1 || da - fv != 2 || rk_valid1 !== 1'b0 || sb1.size() != 0) begin
                errors++;
                $display("FAIL nr1_done p%0d: got count=%0d delay=%0d v=%b left=%0d want 1 2 0 0",
                         pass, dc, da - fv, rk_valid1, sb1.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero_key();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_nr1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
